demux1to4_stream: RTL and testbench
===================================

Name: demux1to4_stream

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshake; the inverse of the team's 4-to-1 mux datapath.
- Routes each accepted input word to one of four output channels, selected by ctrl_sel.
- Each output channel has a one-entry holding slot, so backpressure on one channel does not block traffic to the others.
- Sits between a single producer and four independent consumers.

Parameters:
- DATA_W, 8, width of data_in and of each output word.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block accepts the word this cycle.
- data_in  input  DATA_W  input word.
- ctrl_sel  input  2  destination channel 0..3; sampled only when in_valid=1.
- out_valid  output  4  per-channel slot holds a word.
- out_ready  input  4  per-channel consumer takes the word.
- data_out  output  4*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].

Behaviour:
- Reset: asynchronous, active-low. All slots go EMPTY, out_valid=4'b0000, data_out=0. In-flight words are discarded, with no partial transfer. Reset also clears the optional counters. The first accept is possible on the first rising edge after rst_n deasserts.
- Per-slot state machine:
  - Two states, EMPTY and FULL.
  - EMPTY to FULL on accept to that slot.
  - FULL to EMPTY on out_ready[k] with no same-cycle accept to k.
  - FULL stays FULL on drain plus accept in the same cycle; the new word is loaded.
- in_ready is combinational: in_ready = (slot[ctrl_sel]==EMPTY) | out_ready[ctrl_sel]. It does not depend on in_valid.
- Accept condition: in_valid & in_ready. The word is written into slot ctrl_sel at the edge.
- Latency: out_valid[k] rises exactly 1 cycle after accept. The output is fully registered; there is no combinational path from data_in to data_out.
- Throughput: 1 word per cycle to any single channel, provided that channel's consumer holds out_ready high.
- Output data is stable while out_valid[k]=1 and out_ready[k]=0. The data_out of an EMPTY slot holds its last value and carries no meaning.
- Non-selected channels drain independently in the same cycle as an accept to another channel.
- ctrl_sel or data_in may change while in_valid=0 with no effect.
- Slot full and out_ready=0 on the selected channel: in_ready=0 and the producer must hold the word.
- All four slots full with all out_ready=1: an accept is still allowed (the drain-and-fill rule applies).

Optional Feature:
- Macro: DEMUX1TO4_CNT_EN.
- With the macro defined:
  - Adds output port chan_cnt (4*16 bits), one 16-bit accept counter per channel.
  - A counter increments on each accept to its channel.
  - Counters wrap from 16'hFFFF to 16'h0000 silently.
  - Counters reset to 0.
- Without the macro: no port, no counters, and identical datapath behaviour.

Decomposition:
- Package demux_pkg holds:
  - NUM_OUT=4 and SEL_W=2.
  - CNT_W=16.
  - Typedef slot_state_e {EMPTY, FULL}.
- Sub-module demux_slot: a one-entry buffer with load, drain, state, data register and valid. Instantiate it 4 times with a generate loop.

Test Plan:
- Reset check: rst_n=0 -> out_valid=0000, data_out=0, in_ready=1 for every ctrl_sel.
- Routing: data_in=8'hA5 with ctrl_sel=0..3 in turn, out_ready=1111 -> one cycle later out_valid is one-hot (0001, 0010, 0100, 1000) and the selected lane = A5.
- Backpressure: out_ready[2]=0; send 8'h11 to ch2, then 8'h22 to ch2 -> second word gets in_ready=0 and is held; raise out_ready[2] -> 8'h11 is consumed, 8'h22 is loaded in the same cycle, and out_valid[2] stays 1.
- Independence: ch1 full and stalled; send 8'h33 to ch3 -> in_ready=1 and ch3 delivers 33 next cycle while ch1 data stays unchanged.
- Mid-operation reset: fill all slots, assert rst_n=0 asynchronously between edges -> out_valid=0000 immediately, without waiting for a clock edge.
- With DEMUX1TO4_CNT_EN: 5 accepts to ch0 and 2 to ch3 -> chan_cnt = {16'd2, 16'd0, 16'd0, 16'd5}; preload a counter to FFFF and accept once -> it wraps to 0.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants and types for the demux1to4_stream block.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  // Number of output channels and width of the channel selector
  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  // Width of each optional per-channel accept counter
  localparam int CNT_W   = 16;

  // Occupancy of a one-entry output holding slot
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_slot
//  Description : One-entry output holding slot. Loads a word when the top
//                accepts for this channel, drains when the consumer is ready.
//                Drain and load in the same cycle keeps the slot FULL with
//                the new word.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [DATA_W-1:0] data_out
);

  slot_state_e state;
  slot_state_e state_nxt;

  // Slot occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next occupancy: load wins over drain, so drain+load stays FULL
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (!load && drain) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Data register; holds its value while not loading (stable under stall)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= data_in;
    end
  end

  assign valid = (state == FULL);

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux1to4_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux1to4_stream
//  Description : Registered 1-to-4 stream demultiplexer with valid/ready
//                handshake. Each channel owns a one-entry slot so a stalled
//                consumer only blocks words addressed to its own channel.
//                Optional per-channel 16-bit accept counters are enabled by
//                defining the macro DEMUX1TO4_CNT_EN (adds port chan_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         data_in,
  input  logic [SEL_W-1:0]          ctrl_sel,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] data_out
`ifdef DEMUX1TO4_CNT_EN
  ,
  output logic [NUM_OUT*CNT_W-1:0]  chan_cnt
`endif
);

  logic                accept;
  logic [NUM_OUT-1:0]  load;

  // Selected slot can take a word if empty or draining this cycle;
  // deliberately independent of in_valid
  always_comb begin
    in_ready = ~out_valid[ctrl_sel] | out_ready[ctrl_sel];
    accept   = in_valid & in_ready;
  end

  // Route the accept strobe to the addressed slot only
  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      load[k] = accept && (ctrl_sel == SEL_W'(k));
    end
  end

  generate
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
      demux_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load[k]),
        .drain    (out_ready[k]),
        .data_in  (data_in),
        .valid    (out_valid[k]),
        .data_out (data_out[k*DATA_W +: DATA_W])
      );
    end : g_slot
  endgenerate

`ifdef DEMUX1TO4_CNT_EN
  generate
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_cnt
      logic [CNT_W-1:0] cnt;

      // Per-channel accept counter, wraps silently at all-ones
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (load[k]) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign chan_cnt[k*CNT_W +: CNT_W] = cnt;
    end : g_cnt
  endgenerate
`endif

endmodule : demux1to4_stream
`default_nettype wire

// File: tb/tb_demux1to4_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux1to4_stream
//  Description : Self-checking bench for demux1to4_stream. A behavioural
//                model keeps one occupancy flag and one word per channel.
//                Counter checks are built when DEMUX1TO4_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1to4_stream;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic [1:0]    ctrl_sel;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [4*DW-1:0] data_out;
`ifdef DEMUX1TO4_CNT_EN
  logic [63:0]   chan_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: per-channel occupancy, held word and accept count
  bit          m_full [4];
  logic [DW-1:0] m_data [4];
  logic [15:0] m_cnt  [4];

  demux1to4_stream #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .ctrl_sel  (ctrl_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
`ifdef DEMUX1TO4_CNT_EN
    ,
    .chan_cnt  (chan_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
      m_cnt[k]  = '0;
    end
  endtask

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic bit model_ready();
    return !m_full[ctrl_sel] || out_ready[ctrl_sel];
  endfunction

  // Advance one clock; model consumes the inputs as sampled at the edge
  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = in_valid && (!m_full[ctrl_sel] || out_ready[ctrl_sel]);
    for (int k = 0; k < 4; k++) begin
      if (acc && ctrl_sel == 2'(k)) begin
        m_full[k] = 1'b1;
        m_data[k] = data_in;
        m_cnt[k]  = m_cnt[k] + 16'd1;
      end else if (out_ready[k]) begin
        m_full[k] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; ctrl_sel = '0; out_ready = '0;
    model_clear();
    #3;
    total++;
    if (out_valid !== 4'b0000) begin
      bad++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
    end
    total++;
    if (data_out !== '0) begin
      bad++; $display("FAIL reset_data_out got=%h exp=0", data_out);
    end
    for (int s = 0; s < 4; s++) begin
      ctrl_sel = 2'(s);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, in_ready);
      end
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_routing();
    out_ready = 4'b1111; in_valid = 1'b1; data_in = 8'hA5;
    for (int s = 0; s < 4; s++) begin
      ctrl_sel = 2'(s);
      tick();
      total++;
      if (out_valid !== (4'b0001 << s)) begin
        bad++; $display("FAIL route_valid ch=%0d got=%b exp=%b", s, out_valid, 4'b0001 << s);
      end
      total++;
      if (data_out[s*DW +: DW] !== 8'hA5) begin
        bad++; $display("FAIL route_data ch=%0d got=%h exp=a5", s, data_out[s*DW +: DW]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1011; in_valid = 1'b1; ctrl_sel = 2'd2; data_in = 8'h11;
    tick();
    data_in = 8'h22;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_in_ready_low got=%b exp=0", in_ready);
    end
    tick();
    total++;
    if (out_valid[2] !== 1'b1 || data_out[2*DW +: DW] !== 8'h11) begin
      bad++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=11", out_valid[2], data_out[2*DW +: DW]);
    end
    out_ready = 4'b1111;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_in_ready_high got=%b exp=1", in_ready);
    end
    tick();
    total++;
    if (out_valid[2] !== 1'b1 || data_out[2*DW +: DW] !== 8'h22) begin
      bad++; $display("FAIL bp_drain_fill got v=%b d=%h exp v=1 d=22", out_valid[2], data_out[2*DW +: DW]);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 4'b0000) begin
      bad++; $display("FAIL bp_empty got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_independence();
    out_ready = 4'b1101; in_valid = 1'b1; ctrl_sel = 2'd1; data_in = 8'h44;
    tick();
    ctrl_sel = 2'd3; data_in = 8'h33;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL indep_in_ready got=%b exp=1", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 4'b1010 || data_out[3*DW +: DW] !== 8'h33 || data_out[1*DW +: DW] !== 8'h44) begin
      bad++; $display("FAIL indep_out got v=%b d3=%h d1=%h exp v=1010 d3=33 d1=44",
                      out_valid, data_out[3*DW +: DW], data_out[1*DW +: DW]);
    end
    in_valid = 1'b0; out_ready = 4'b1111;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      ctrl_sel  = 2'($urandom_range(0, 3));
      data_in   = 8'($urandom);
      out_ready = 4'($urandom);
      #1;
      total++;
      if (in_ready !== model_ready()) begin
        bad++; $display("FAIL rand_in_ready i=%0d got=%b exp=%b", i, in_ready, model_ready());
      end
      tick();
      total++;
      if (out_valid !== model_valid()) begin
        bad++; $display("FAIL rand_out_valid i=%0d got=%b exp=%b", i, out_valid, model_valid());
      end
      for (int k = 0; k < 4; k++) begin
        if (m_full[k]) begin
          total++;
          if (data_out[k*DW +: DW] !== m_data[k]) begin
            bad++; $display("FAIL rand_data i=%0d ch=%0d got=%h exp=%h", i, k, data_out[k*DW +: DW], m_data[k]);
          end
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 4'b0000; in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      ctrl_sel = 2'(s); data_in = 8'(8'h60 + s);
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 4'b1111) begin
      bad++; $display("FAIL areset_fill got=%b exp=1111", out_valid);
    end
    // Assert reset mid-cycle, well away from either clock edge
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 4'b0000 || data_out !== '0) begin
      bad++; $display("FAIL areset_immediate got v=%b d=%h exp v=0000 d=0", out_valid, data_out);
    end
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 4'b1111;
  endtask

`ifdef DEMUX1TO4_CNT_EN
  task automatic test_counters();
    out_ready = 4'b1111; in_valid = 1'b1;
    ctrl_sel = 2'd0;
    for (int i = 0; i < 5; i++) begin data_in = 8'(i); tick(); end
    ctrl_sel = 2'd3;
    for (int i = 0; i < 2; i++) begin data_in = 8'(i); tick(); end
    in_valid = 1'b0;
    total++;
    if (chan_cnt !== {16'd2, 16'd0, 16'd0, 16'd5}) begin
      bad++; $display("FAIL cnt_basic got=%h exp=%h", chan_cnt, {16'd2, 16'd0, 16'd0, 16'd5});
    end
    // Bring channel 0 up to all-ones, then one more accept must wrap it
    in_valid = 1'b1; ctrl_sel = 2'd0;
    for (int i = 0; i < 65530; i++) tick();
    in_valid = 1'b0;
    total++;
    if (chan_cnt[15:0] !== 16'hFFFF || chan_cnt[15:0] !== m_cnt[0]) begin
      bad++; $display("FAIL cnt_full got=%h exp=ffff", chan_cnt[15:0]);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (chan_cnt[15:0] !== 16'h0000) begin
      bad++; $display("FAIL cnt_wrap got=%h exp=0000", chan_cnt[15:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_independence();
    test_random();
    test_async_reset();
`ifdef DEMUX1TO4_CNT_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux1to4_stream
`default_nettype wire
